carpark_slot_manager: RTL and testbench
=======================================

CARPARK_SLOT_MANAGER -- requirements
Module: carpark_slot_manager

Interface
REQ-001 Parameter N_SLOTS, default 16, number of parking slots; slot index width 4.
REQ-002 Parameter VN_W, default 4, vehicle-number width; vn 0 reserved as "no vehicle".
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 park_valid  input  1  park request from the gate controller; held until accepted.
REQ-006 park_vn  input  VN_W  vehicle number to park; stable while park_valid is high.
REQ-007 exit_valid  input  1  exit request; held until accepted.
REQ-008 exit_vn  input  VN_W  vehicle number leaving; stable while exit_valid is high.
REQ-009 req_ready  output  1  high only in IDLE; a request is accepted on an edge where valid and req_ready are both high.
REQ-010 resp_valid  output  1  one-cycle result strobe.
REQ-011 resp_op  output  1  0 = park result, 1 = exit result.
REQ-012 resp_ok  output  1  operation succeeded.
REQ-013 resp_slot  output  4  slot allocated (park) or freed (exit); 0 when resp_ok=0.
REQ-014 resp_err  output  2  00 none, 01 full, 10 duplicate (park) or not-found (exit), 11 bad vn.
REQ-015 free_cnt  output  5  number of free slots, 0..16.
REQ-016 full / empty  output  1 each  free_cnt==0 / free_cnt==16.

Function
REQ-017 The FSM SHALL have the states IDLE, SCAN and RESP; the transitions are IDLE->SCAN on accept, SCAN->RESP after index 15, and RESP->IDLE unconditionally.
REQ-018 Simultaneous park_valid and exit_valid in IDLE: park SHALL be accepted, and exit SHALL stay pending for the next IDLE.
REQ-019 On accept, the block SHALL latch the op and vn, clear the scan results and set scan index 0.
REQ-020 SCAN SHALL examine one slot per cycle (indices 0..15, 16 cycles) and record the lowest free index, a vn-match flag and the match index.
REQ-021 resp_valid SHALL be high for exactly one cycle (the RESP state), beginning 17 edges after the accept edge; the total request-to-ready turnaround SHALL be 18 cycles.
REQ-022 The park error priority SHALL be bad vn (vn==0) > duplicate (vn already stored) > full; on success the block SHALL mark the lowest free slot valid, store the vn, report that slot, and decrement free_cnt.
REQ-023 The exit error priority SHALL be bad vn > not-found; on success the block SHALL clear the matching slot, report its index, and increment free_cnt.
REQ-024 The table SHALL be updated only on the RESP entry edge; free_cnt, full and empty SHALL change in the same cycle that resp_valid is high.
REQ-025 free_cnt SHALL never wrap: a full park SHALL leave it at 0, and no increment SHALL occur past 16 (guaranteed by the not-found check).
REQ-026 A failed request SHALL leave the table and free_cnt unchanged.
REQ-027 Inputs SHALL be ignored outside IDLE; a change in vn after accept SHALL have no effect.

Reset
REQ-028 Reset SHALL force: FSM to IDLE, all slots invalid, stored vn 0, free_cnt 16, empty 1, full 0, req_ready 1, resp_valid 0, resp_ok 0, resp_slot 0, resp_err 00, resp_op 0.
REQ-029 Reset asserted mid-SCAN or in RESP SHALL abort the request with no response and no table change surviving.
REQ-030 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-031 A shared package carpark_pkg SHALL hold the N_SLOTS and VN_W defaults, the resp_err codes, the resp_op codes and the FSM state encoding.
REQ-032 One sub-module, carpark_slot_table, SHALL hold the 16 x (valid, vn) storage with a read port (index) and a write port (index, valid, vn); the FSM stays in carpark_slot_manager.

Verification
REQ-033 After reset, park vn=5: resp at cycle 17 after accept with ok=1, slot=0, err=00; then free_cnt=15 and empty=0.
REQ-034 Park vn=5 again: ok=0, err=10, slot=0; free_cnt stays 15.
REQ-035 Park vn=1..15 then vn=3 (16 parks with a duplicate check): the first 15 park in slots 0..14, and the duplicate is rejected with err=10; 16 distinct parks SHALL set full=1, and a 17th SHALL return err=01.
REQ-036 park_valid and exit_valid both high (park vn=7, exit vn=5): the park response comes first; the exit is accepted the cycle after return to IDLE, frees slot 0, and the next park of vn=9 is allocated slot 0.
REQ-037 Exit vn=12 not stored -> err=10; park or exit with vn=0 -> err=11; neither changes free_cnt.
REQ-038 rst_n pulled low at scan index 8 of a park: no resp_valid, free_cnt=16, and a following park of vn=4 yields slot 0.

Source files
------------

// File: rtl/carpark_pkg.sv
// Shared types and defaults for the car-park slot manager: error/op codes and FSM encoding.
package carpark_pkg;

  localparam int N_SLOTS_DEF = 16;
  localparam int VN_W_DEF    = 4;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_FULL   = 2'b01,
    ERR_DUP_NF = 2'b10,   // duplicate on park, not-found on exit
    ERR_BAD_VN = 2'b11
  } resp_err_e;

  typedef enum logic {
    OP_PARK = 1'b0,
    OP_EXIT = 1'b1
  } resp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/carpark_slot_manager_if.sv
// Request/response bundle between the gate controller (master) and the slot manager (slave).
interface carpark_slot_manager_if import carpark_pkg::*; #(
  parameter int N_SLOTS = N_SLOTS_DEF,
  parameter int VN_W    = VN_W_DEF
);

  logic                           park_valid;
  logic [VN_W-1:0]                park_vn;
  logic                           exit_valid;
  logic [VN_W-1:0]                exit_vn;
  logic                           req_ready;
  logic                           resp_valid;
  logic                           resp_op;
  logic                           resp_ok;
  logic [$clog2(N_SLOTS)-1:0]     resp_slot;
  logic [1:0]                     resp_err;
  logic [$clog2(N_SLOTS+1)-1:0]   free_cnt;
  logic                           full;
  logic                           empty;

  modport master (
    output park_valid, park_vn, exit_valid, exit_vn,
    input  req_ready, resp_valid, resp_op, resp_ok, resp_slot, resp_err,
           free_cnt, full, empty
  );

  modport slave (
    input  park_valid, park_vn, exit_valid, exit_vn,
    output req_ready, resp_valid, resp_op, resp_ok, resp_slot, resp_err,
           free_cnt, full, empty
  );

endinterface

// File: rtl/carpark_slot_table.sv
// Slot storage: N_SLOTS x (valid, vn) with a registered read port and one write port.
module carpark_slot_table import carpark_pkg::*; #(
  parameter int N_SLOTS = N_SLOTS_DEF,
  parameter int VN_W    = VN_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(N_SLOTS)-1:0] i_rd_idx,
  output logic                       o_rd_valid,
  output logic [VN_W-1:0]            o_rd_vn,
  input  logic                       i_wr_en,
  input  logic [$clog2(N_SLOTS)-1:0] i_wr_idx,
  input  logic                       i_wr_valid,
  input  logic [VN_W-1:0]            i_wr_vn
);

  logic            r_valid [N_SLOTS];
  logic [VN_W-1:0] r_vn    [N_SLOTS];
  logic            r_rd_valid;
  logic [VN_W-1:0] r_rd_vn;

  // NOTE: every entry is reset because an empty car park must come up with no
  // stale vehicles; this keeps the table in flops rather than an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        r_valid[i] <= 1'b0;
        r_vn[i]    <= '0;
      end
      r_rd_valid <= 1'b0;
      r_rd_vn    <= '0;
    end else begin
      // NOTE: non-blocking so the read below sees the pre-write contents.
      if (i_wr_en) begin
        r_valid[i_wr_idx] <= i_wr_valid;
        r_vn[i_wr_idx]    <= i_wr_vn;
      end
      r_rd_valid <= r_valid[i_rd_idx];
      r_rd_vn    <= r_vn[i_rd_idx];
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_vn    = r_rd_vn;

endmodule

// File: rtl/carpark_slot_manager.sv
// Car-park slot manager: accepts park/exit requests, scans the table one slot per cycle,
// then commits the result and emits a one-cycle response.
module carpark_slot_manager import carpark_pkg::*; #(
  parameter int N_SLOTS = N_SLOTS_DEF,
  parameter int VN_W    = VN_W_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  carpark_slot_manager_if.slave  bus
);

  localparam int IDX_W = $clog2(N_SLOTS);
  localparam int CNT_W = $clog2(N_SLOTS + 1);
  localparam logic [IDX_W:0]   LAST_IDX = (IDX_W+1)'(N_SLOTS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_SLOTS);

  state_e             r_state;
  resp_op_e           r_op;
  logic [VN_W-1:0]    r_vn;
  logic [IDX_W:0]     r_idx;
  logic               r_free_found, r_match;
  logic [IDX_W-1:0]   r_free_idx, r_match_idx;
  logic [CNT_W-1:0]   r_free_cnt;
  logic               r_ready, r_resp_valid, r_resp_ok, r_full, r_empty;
  resp_op_e           r_resp_op;
  resp_err_e          r_resp_err;
  logic [IDX_W-1:0]   r_resp_slot;

  logic               w_rd_valid, w_chk, w_last, w_free_found, w_match, w_ok;
  logic [VN_W-1:0]    w_rd_vn, w_wr_vn;
  logic [IDX_W-1:0]   w_chk_idx, w_free_idx, w_match_idx, w_slot;
  logic               w_wr_en, w_wr_valid;
  resp_err_e          w_err;
  logic [CNT_W-1:0]   w_cnt_nxt;

  carpark_slot_table #(.N_SLOTS(N_SLOTS), .VN_W(VN_W)) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (r_idx[IDX_W-1:0]),
    .o_rd_valid (w_rd_valid),
    .o_rd_vn    (w_rd_vn),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_slot),
    .i_wr_valid (w_wr_valid),
    .i_wr_vn    (w_wr_vn)
  );

  // Read data lags the scan index by one cycle, so slot r_idx-1 is examined
  // here and the final slot is folded straight into the commit decision.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    w_chk        = (r_state == ST_SCAN) && (r_idx != '0);
    w_last       = (r_state == ST_SCAN) && (r_idx == LAST_IDX);
    w_chk_idx    = IDX_W'(r_idx - (IDX_W+1)'(1));
    w_free_found = r_free_found;
    w_free_idx   = r_free_idx;
    w_match      = r_match;
    w_match_idx  = r_match_idx;
    if (w_chk) begin
      if (!w_rd_valid && !r_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = w_chk_idx;
      end
      if (w_rd_valid && (w_rd_vn == r_vn) && !r_match) begin
        w_match     = 1'b1;
        w_match_idx = w_chk_idx;
      end
    end

    w_err      = ERR_NONE;
    w_ok       = 1'b0;
    w_slot     = '0;
    w_wr_valid = 1'b0;
    w_wr_vn    = '0;
    w_cnt_nxt  = r_free_cnt;
    if (r_vn == '0) begin
      w_err = ERR_BAD_VN;
    end else if (r_op == OP_PARK) begin
      if (w_match)            w_err = ERR_DUP_NF;
      else if (!w_free_found) w_err = ERR_FULL;
      else begin
        w_ok       = 1'b1;
        w_slot     = w_free_idx;
        w_wr_valid = 1'b1;
        w_wr_vn    = r_vn;
        w_cnt_nxt  = r_free_cnt - CNT_W'(1);
      end
    end else begin
      if (!w_match) w_err = ERR_DUP_NF;
      else begin
        w_ok      = 1'b1;
        w_slot    = w_match_idx;
        w_cnt_nxt = r_free_cnt + CNT_W'(1);
      end
    end
    w_wr_en = w_last && w_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_PARK;
      r_vn         <= '0;
      r_idx        <= '0;
      r_free_found <= 1'b0;
      r_match      <= 1'b0;
      r_free_idx   <= '0;
      r_match_idx  <= '0;
      r_free_cnt   <= CNT_MAX;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_op    <= OP_PARK;
      r_resp_ok    <= 1'b0;
      r_resp_err   <= ERR_NONE;
      r_resp_slot  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Park wins a tie; a held exit is picked up on the next visit to IDLE.
          if (bus.park_valid || bus.exit_valid) begin
            r_op         <= bus.park_valid ? OP_PARK : OP_EXIT;
            r_vn         <= bus.park_valid ? bus.park_vn : bus.exit_vn;
            r_idx        <= '0;
            r_free_found <= 1'b0;
            r_match      <= 1'b0;
            r_free_idx   <= '0;
            r_match_idx  <= '0;
            r_ready      <= 1'b0;
            r_state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_free_found <= w_free_found;
          r_free_idx   <= w_free_idx;
          r_match      <= w_match;
          r_match_idx  <= w_match_idx;
          r_idx        <= r_idx + (IDX_W+1)'(1);
          if (w_last) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_op    <= r_op;
            r_resp_ok    <= w_ok;
            r_resp_err   <= w_err;
            r_resp_slot  <= w_slot;
            r_free_cnt   <= w_cnt_nxt;
            r_full       <= (w_cnt_nxt == '0);
            r_empty      <= (w_cnt_nxt == CNT_MAX);
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_op    = r_resp_op;
  assign bus.resp_ok    = r_resp_ok;
  assign bus.resp_slot  = r_resp_slot;
  assign bus.resp_err   = r_resp_err;
  assign bus.free_cnt   = r_free_cnt;
  assign bus.full       = r_full;
  assign bus.empty      = r_empty;

endmodule

// File: tb/tb_carpark_slot_manager.sv
// Bench for carpark_slot_manager: directed and random park/exit traffic checked against
// an array model of the car park (slot -> vn, 0 = free).
module tb_carpark_slot_manager;

  // Wide enough vn that sixteen distinct vehicles exist and the full boundary is reachable.
  localparam int TB_VN_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  carpark_slot_manager_if #(.N_SLOTS(16), .VN_W(TB_VN_W)) bus ();

  carpark_slot_manager #(.N_SLOTS(16), .VN_W(TB_VN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_slot [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_free();
    int n = 0;
    foreach (m_slot[i]) if (m_slot[i] == 0) n++;
    return n;
  endfunction

  function automatic void model_apply(input bit is_exit, input int vn,
                                      output bit ok, output int slot, output int err);
    int found = -1;
    int free  = -1;
    foreach (m_slot[i]) begin
      if (vn != 0 && m_slot[i] == vn && found < 0) found = i;
      if (m_slot[i] == 0 && free < 0) free = i;
    end
    ok = 1'b0; slot = 0; err = 0;
    if (vn == 0) err = 3;
    else if (!is_exit) begin
      if (found >= 0)    err = 2;
      else if (free < 0) err = 1;
      else begin ok = 1'b1; slot = free; m_slot[free] = vn; end
    end else begin
      if (found < 0) err = 2;
      else begin ok = 1'b1; slot = found; m_slot[found] = 0; end
    end
  endfunction

  // Entered at a negedge with a valid raised; returns at the negedge after the accept edge.
  task automatic wait_accept(input string tag, output int waits);
    waits = 0;
    while (bus.req_ready !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    check({tag, " accept_in_time"}, 32'(waits < 40), 1);
    @(negedge clk);
    check({tag, " busy_after_accept"}, bus.req_ready, 0);
  endtask

  task automatic wait_resp(input bit is_exit, input int vn, input string tag);
    bit ok;
    int slot, err, old_free, fr;
    int lat = 0;
    old_free = model_free();
    model_apply(is_exit, vn, ok, slot, err);
    fr = model_free();
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) lat = k;
      else if (k == 16) check({tag, " free_cnt_before_resp"}, bus.free_cnt, old_free);
    end
    check({tag, " latency"},  lat, 17);
    check({tag, " resp_op"},  bus.resp_op, is_exit);
    check({tag, " resp_ok"},  bus.resp_ok, ok);
    check({tag, " resp_slot"}, bus.resp_slot, slot);
    check({tag, " resp_err"}, bus.resp_err, err);
    check({tag, " free_cnt"}, bus.free_cnt, fr);
    check({tag, " full"},     bus.full, 32'(fr == 0));
    check({tag, " empty"},    bus.empty, 32'(fr == 16));
    @(negedge clk);
    check({tag, " strobe_width"}, bus.resp_valid, 0);
    check({tag, " ready_back"},   bus.req_ready, 1);
  endtask

  task automatic issue(input bit is_exit, input int vn, input string tag);
    int waits;
    if (is_exit) begin bus.exit_valid = 1'b1; bus.exit_vn = TB_VN_W'(vn); end
    else         begin bus.park_valid = 1'b1; bus.park_vn = TB_VN_W'(vn); end
    wait_accept(tag, waits);
    bus.park_valid = 1'b0;
    bus.exit_valid = 1'b0;
    bus.park_vn    = TB_VN_W'($urandom);
    bus.exit_vn    = TB_VN_W'($urandom);
    wait_resp(is_exit, vn, tag);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.park_valid = 1'b0;
    bus.exit_valid = 1'b0;
    repeat (2) @(negedge clk);
    foreach (m_slot[i]) m_slot[i] = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  waits, vn, seen;
    bit  ex;
    bus.park_valid = 1'b0;
    bus.exit_valid = 1'b0;
    bus.park_vn    = '0;
    bus.exit_vn    = '0;
    apply_reset();

    check("rst req_ready",  bus.req_ready, 1);
    check("rst resp_valid", bus.resp_valid, 0);
    check("rst resp_ok",    bus.resp_ok, 0);
    check("rst resp_slot",  bus.resp_slot, 0);
    check("rst resp_err",   bus.resp_err, 0);
    check("rst resp_op",    bus.resp_op, 0);
    check("rst free_cnt",   bus.free_cnt, 16);
    check("rst empty",      bus.empty, 1);
    check("rst full",       bus.full, 0);

    issue(0, 5,  "park5");
    issue(0, 5,  "park5_dup");
    issue(1, 12, "exit12_notfound");
    issue(0, 0,  "park0_badvn");
    issue(1, 0,  "exit0_badvn");

    // Park and exit raised together: park first, exit picked up on the first IDLE edge.
    bus.park_valid = 1'b1; bus.park_vn = TB_VN_W'(7);
    bus.exit_valid = 1'b1; bus.exit_vn = TB_VN_W'(5);
    wait_accept("both_park", waits);
    bus.park_valid = 1'b0;
    wait_resp(0, 7, "both_park");
    wait_accept("both_exit", waits);
    check("both_exit accept_wait", waits, 0);
    bus.exit_valid = 1'b0;
    wait_resp(1, 5, "both_exit");
    issue(0, 9, "park9_reuse");

    apply_reset();
    for (int v = 1; v <= 15; v++) issue(0, v, "fill");
    issue(0, 3,  "fill_dup");
    issue(0, 16, "fill_last");
    issue(0, 17, "park_when_full");
    issue(1, 8,  "exit_from_full");

    repeat (60) begin
      ex = ($urandom_range(0, 9) < 4);
      vn = $urandom_range(0, 20);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(ex, vn, ex ? "rand_exit" : "rand_park");
    end

    // Abort a park at scan index 8 with reset.
    bus.park_valid = 1'b1; bus.park_vn = TB_VN_W'(6);
    wait_accept("abort_park", waits);
    bus.park_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    seen  = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) seen = 1;
    end
    check("abort no_resp",    seen, 0);
    check("abort free_cnt",   bus.free_cnt, 16);
    check("abort empty",      bus.empty, 1);
    check("abort req_ready",  bus.req_ready, 1);
    foreach (m_slot[i]) m_slot[i] = 0;
    rst_n = 1'b1;
    bus.park_valid = 1'b1; bus.park_vn = TB_VN_W'(4);
    wait_accept("post_reset_park", waits);
    check("post_reset first_edge_accept", waits, 0);
    bus.park_valid = 1'b0;
    wait_resp(0, 4, "post_reset_park");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
